// File: rtl/switch_event_ctrl.sv
// One-shot switch-majority event controller: sync + debounce the button, sample switches once per press,
// pulse event/reject on popcount vs THRESH. Define SEC_EVENT_COUNTER_EN for a saturating event counter.
module switch_event_ctrl #(
    parameter int SW_W     = 10,
    parameter int THRESH   = 3,
    parameter int DEB_CYC  = 16,
    parameter int HOLD_CYC = 8,
    parameter int CNT_W    = 8
) (
    input  logic                      SEC_CLK50MHZ,
    input  logic                      SEC_rst_n,
    input  logic [SW_W-1:0]           SEC_sw,
    input  logic                      SEC_btn,
    input  logic                      SEC_en,
    output logic                      SEC_event,
    output logic                      SEC_reject,
    output logic [$clog2(SW_W+1)-1:0] SEC_popcnt,
    output logic                      SEC_busy
`ifdef SEC_EVENT_COUNTER_EN
    ,output logic [CNT_W-1:0]         SEC_event_cnt
`endif
);
    localparam int PCW  = $clog2(SW_W + 1);
    localparam int TMAX = (DEB_CYC > HOLD_CYC) ? DEB_CYC : HOLD_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] DEB_LAST  = TW'(DEB_CYC - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
    localparam logic [31:0]   THR       = THRESH;

    typedef enum logic [2:0] {IDLE, DEBOUNCE, EVAL, HOLDOFF, WAIT_REL} state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   cnt, cnt_nx;
    logic            btn_m, btn_s, btn_d;
    logic [SW_W-1:0] sw_m, sw_s;
    logic [1:0]      settle;
    logic            armed;
    logic            rise, latch, hit;
    logic [PCW-1:0]  pc;

    // Synchronisers plus an arm flag: after reset the synced button must be
    // seen low once, so a button held through reset cannot fire a press.
    always_ff @(posedge SEC_CLK50MHZ or negedge SEC_rst_n) begin
        if (!SEC_rst_n) begin
            btn_m  <= 1'b0;
            btn_s  <= 1'b0;
            btn_d  <= 1'b0;
            sw_m   <= '0;
            sw_s   <= '0;
            settle <= 2'd0;
            armed  <= 1'b0;
        end else begin
            btn_m <= SEC_btn;
            btn_s <= btn_m;
            btn_d <= btn_s;
            sw_m  <= SEC_sw;
            sw_s  <= sw_m;
            if (settle != 2'd2) settle <= settle + 2'd1;
            if (settle == 2'd2 && !btn_s) armed <= 1'b1;
        end
    end

    assign rise = btn_s & ~btn_d;

    always_comb begin
        pc = '0;
        for (int i = 0; i < SW_W; i++) pc = pc + PCW'(sw_s[i]);
    end

    assign hit = (32'(pc) >= THR);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        latch    = 1'b0;
        case (state)
            IDLE: begin
                if (rise && SEC_en && armed) begin
                    state_nx = DEBOUNCE;
                    cnt_nx   = '0;
                end
            end
            DEBOUNCE: begin
                if (!btn_s || !SEC_en)  state_nx = IDLE;
                else if (cnt == DEB_LAST) state_nx = EVAL;
                else                    cnt_nx   = cnt + TW'(1);
            end
            EVAL: begin
                latch    = 1'b1;
                state_nx = HOLDOFF;
                cnt_nx   = '0;
            end
            HOLDOFF: begin
                // A released button skips WAIT_REL entirely.
                if (cnt == HOLD_LAST) state_nx = btn_s ? WAIT_REL : IDLE;
                else                  cnt_nx   = cnt + TW'(1);
            end
            WAIT_REL: begin
                if (!btn_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge SEC_CLK50MHZ or negedge SEC_rst_n) begin
        if (!SEC_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            SEC_event  <= 1'b0;
            SEC_reject <= 1'b0;
            SEC_popcnt <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            SEC_event  <= latch & hit;
            SEC_reject <= latch & ~hit;
            if (latch) SEC_popcnt <= pc;
        end
    end

    assign SEC_busy = (state != IDLE);

`ifdef SEC_EVENT_COUNTER_EN
    always_ff @(posedge SEC_CLK50MHZ or negedge SEC_rst_n) begin
        if (!SEC_rst_n)
            SEC_event_cnt <= '0;
        else if (latch && hit && SEC_event_cnt != {CNT_W{1'b1}})
            SEC_event_cnt <= SEC_event_cnt + CNT_W'(1);
    end
`endif

endmodule
